i2c_txn_arbiter: RTL and testbench

- Shares one I2C master engine between NUM_REQ requesters (sensor pollers, config loader, host CPU bridge).
- Each requester posts a single-byte transaction: rw, 7-bit slave address, write byte.
- The arbiter grants the bus round-robin, sequences the master through start/wait/complete, returns read data and status, and aborts hung transactions on timeout.
- Sits between the requester fabric and the master core; it drives the master's command inputs and consumes its completion outputs.

---
 rtl/i2c_txn_arbiter_if.sv | 53 +++++
 rtl/i2c_txn_arbiter.sv | 170 +++++++++++++++++
 tb/tb_i2c_txn_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_txn_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : i2c_txn_arbiter_if
// Description : Bundle of the requester-fabric and I2C-master-engine signals
//               that surround the transaction arbiter.
//   Requester side : req, req_rw, req_addr, req_wdata (to arbiter)
//                    gnt, done, rdata, err          (from arbiter)
//   Master side    : m_start, m_rw, m_addr, m_wdata, m_abort (from arbiter)
//                    m_busy, m_done, m_nack, m_rdata        (to arbiter)
//   Modports       : slave  - the arbiter's view (it serves the requesters)
//                    master - the surrounding fabric / engine view
// Revision    : 1.0  initial release
// ============================================================================
interface i2c_txn_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 8
);
  // requester fabric
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ-1:0]        req_rw;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rdata;
  logic                      err;
  // I2C master engine
  logic                      m_start;
  logic                      m_rw;
  logic [ADDR_W-1:0]         m_addr;
  logic [DATA_W-1:0]         m_wdata;
  logic                      m_abort;
  logic                      m_busy;
  logic                      m_done;
  logic                      m_nack;
  logic [DATA_W-1:0]         m_rdata;

  modport slave (
    input  req, req_rw, req_addr, req_wdata,
    input  m_busy, m_done, m_nack, m_rdata,
    output gnt, done, rdata, err,
    output m_start, m_rw, m_addr, m_wdata, m_abort
  );

  modport master (
    output req, req_rw, req_addr, req_wdata,
    output m_busy, m_done, m_nack, m_rdata,
    input  gnt, done, rdata, err,
    input  m_start, m_rw, m_addr, m_wdata, m_abort
  );
endinterface
`default_nettype wire

// File: rtl/i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : i2c_txn_arbiter
// Description : Round-robin arbiter sharing one I2C master engine among
//               NUM_REQ requesters. Latches the winning request, strobes the
//               master, waits for completion (or times out and aborts), then
//               returns read data / status with a one-cycle done pulse.
// Ports       : clk  - system clock, rising edge
//               rst  - asynchronous reset, active low
//               bus  - i2c_txn_arbiter_if.slave (requester + master signals)
// Revision    : 1.0  initial release
// ============================================================================
module i2c_txn_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 7,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  i2c_txn_arbiter_if.slave bus
);

  localparam int c_idx_w = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int c_sum_w = c_idx_w + 1;
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES);

  // The abort decision is taken in the cycle whose counter is T-2 so that the
  // registered counter reaches T-1 together with the m_abort pulse.
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 2);
  localparam logic [c_idx_w-1:0] c_ptr_rst  = c_idx_w'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] c_one      = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t               r_state;
  logic [c_idx_w-1:0]   r_ptr;
  logic [c_idx_w-1:0]   r_idx;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   r_done;
  logic [DATA_W-1:0]    r_rdata;
  logic                 r_err;
  logic                 r_start;
  logic                 r_abort;
  logic                 r_rw;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;

  // --------------------------------------------------------------------------
  // Round-robin pick: first set req bit searching upward from r_ptr+1,
  // wrapping at NUM_REQ. The last-granted index therefore has lowest priority.
  // --------------------------------------------------------------------------
  logic                 w_found;
  logic [c_idx_w-1:0]   w_sel;
  logic [c_sum_w-1:0]   w_cand;

  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = {1'b0, r_ptr} + c_sum_w'(k);
      if (w_cand >= c_sum_w'(NUM_REQ)) begin
        w_cand = w_cand - c_sum_w'(NUM_REQ);
      end
      if (!w_found && bus.req[w_cand[c_idx_w-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[c_idx_w-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Transaction sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= c_ptr_rst;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_start <= 1'b0;
      r_abort <= 1'b0;
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      // strobes are single-cycle unless re-asserted below
      r_start <= 1'b0;
      r_abort <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_gnt   <= '0;
          r_done  <= '0;
          r_rdata <= '0;
          r_err   <= 1'b0;
          if (w_found) begin
            r_idx   <= w_sel;
            r_gnt   <= c_one << w_sel;
            r_rw    <= bus.req_rw[w_sel];
            r_addr  <= bus.req_addr[w_sel*ADDR_W +: ADDR_W];
            r_wdata <= bus.req_wdata[w_sel*DATA_W +: DATA_W];
            r_state <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          if (!bus.m_busy) begin
            r_start <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_WAIT;
          end
        end

        S_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          // completion has priority over a timeout on the same cycle
          if (bus.m_done) begin
            r_rdata <= r_rw ? bus.m_rdata : '0;
            r_err   <= bus.m_nack;
            r_done  <= r_gnt;
            r_state <= S_RESP;
          end else if (r_cnt == c_cnt_last) begin
            r_abort <= 1'b1;
            r_err   <= 1'b1;
            r_rdata <= '0;
            r_done  <= r_gnt;
            r_state <= S_RESP;
          end
        end

        S_RESP: begin
          r_ptr   <= r_idx;
          r_gnt   <= '0;
          r_done  <= '0;
          r_rdata <= '0;
          r_err   <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt     = r_gnt;
  assign bus.done    = r_done;
  assign bus.rdata   = r_rdata;
  assign bus.err     = r_err;
  assign bus.m_start = r_start;
  assign bus.m_abort = r_abort;
  assign bus.m_rw    = r_rw;
  assign bus.m_addr  = r_addr;
  assign bus.m_wdata = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_i2c_txn_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_txn_arbiter
// Description : Directed self-checking bench for i2c_txn_arbiter. Instance
//               dut uses the default timeout; dut_to uses TIMEOUT_CYCLES=16.
// Revision    : 1.0  initial release
// ============================================================================
module tb_i2c_txn_arbiter;

  localparam int NR = 4;
  localparam int AW = 7;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  i2c_txn_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) ia ();
  i2c_txn_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) ib ();

  i2c_txn_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  i2c_txn_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(16)) dut_to (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

  // continuous invariants, sampled mid-cycle
  always @(negedge clk) begin
    if (rst) begin
      total++;
      if (!$onehot0(ia.gnt) || !$onehot0(ib.gnt) ||
          (ia.m_start && ia.m_abort) || (ib.m_start && ib.m_abort)) begin
        bad++;
        $display("FAIL invariant: gnt_a=%b gnt_b=%b start_abort_a=%b%b start_abort_b=%b%b required zero/one-hot gnt and no start with abort",
                 ia.gnt, ib.gnt, ia.m_start, ia.m_abort, ib.m_start, ib.m_abort);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start_a(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (ia.m_start) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen && ia.m_start) seen = 1'b1;
  endtask

  task automatic wait_start_b(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (ib.m_start) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    if (!seen && ib.m_start) seen = 1'b1;
  endtask

  task automatic init_inputs();
    ia.req = '0; ia.req_rw = '0; ia.req_addr = '0; ia.req_wdata = '0;
    ia.m_busy = 1'b0; ia.m_done = 1'b0; ia.m_nack = 1'b0; ia.m_rdata = '0;
    ib.req = '0; ib.req_rw = '0; ib.req_addr = '0; ib.req_wdata = '0;
    ib.m_busy = 1'b0; ib.m_done = 1'b0; ib.m_nack = 1'b0; ib.m_rdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    ia.req = 4'b1111; ib.req = 4'b1111;
    step();
    step();
    total++; if (ia.gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt: got %b want 0000", ia.gnt); end
    total++; if (ia.done !== 4'b0000 || ia.err !== 1'b0 || ia.rdata !== 8'h00) begin bad++; $display("FAIL reset_resp: done=%b err=%b rdata=%h want 0/0/00", ia.done, ia.err, ia.rdata); end
    total++; if (ia.m_start !== 1'b0 || ia.m_abort !== 1'b0) begin bad++; $display("FAIL reset_strobes: start=%b abort=%b want 0/0", ia.m_start, ia.m_abort); end
    total++; if (ia.m_rw !== 1'b0 || ia.m_addr !== 7'h00 || ia.m_wdata !== 8'h00) begin bad++; $display("FAIL reset_cmd: rw=%b addr=%h wdata=%h want 0/00/00", ia.m_rw, ia.m_addr, ia.m_wdata); end
    total++; if (ib.gnt !== 4'b0000) begin bad++; $display("FAIL reset_gnt_b: got %b want 0000", ib.gnt); end
    ia.req = '0; ib.req = '0;
    rst = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    bit seen;
    int extra;
    ia.req_rw    = 4'b0100;
    ia.req_addr  = '0;
    ia.req_addr[2*AW +: AW] = 7'h48;
    ia.req_wdata = 32'h11223344;
    ia.req       = 4'b0100;
    step();
    total++; if (ia.gnt !== 4'b0100) begin bad++; $display("FAIL read_gnt: got %b want 0100", ia.gnt); end
    total++; if (ia.m_addr !== 7'h48 || ia.m_rw !== 1'b1 || ia.m_start !== 1'b0) begin bad++; $display("FAIL read_latch: addr=%h rw=%b start=%b want 48/1/0", ia.m_addr, ia.m_rw, ia.m_start); end
    step();
    total++; if (ia.m_start !== 1'b1) begin bad++; $display("FAIL read_start: got %b want 1", ia.m_start); end
    extra = 0;
    for (int i = 1; i < 40; i++) begin
      step();
      if (ia.m_start) extra++;
    end
    total++; if (extra != 0) begin bad++; $display("FAIL read_one_start: extra starts=%0d want 0", extra); end
    ia.m_done = 1'b1; ia.m_rdata = 8'hF6;
    step();
    ia.m_done = 1'b0; ia.m_rdata = 8'h00;
    total++; if (ia.done !== 4'b0100 || ia.rdata !== 8'hF6 || ia.err !== 1'b0 || ia.gnt !== 4'b0100) begin bad++; $display("FAIL read_done: done=%b rdata=%h err=%b gnt=%b want 0100/f6/0/0100", ia.done, ia.rdata, ia.err, ia.gnt); end
    ia.req = '0;
    step();
    total++; if (ia.done !== 4'b0000 || ia.gnt !== 4'b0000 || ia.rdata !== 8'h00) begin bad++; $display("FAIL read_clear: done=%b gnt=%b rdata=%h want 0000/0000/00", ia.done, ia.gnt, ia.rdata); end
    step();
  endtask

  task automatic test_stray_done();
    ia.m_done = 1'b1; ia.m_rdata = 8'hEE;
    step();
    ia.m_done = 1'b0; ia.m_rdata = 8'h00;
    step();
    total++; if (ia.done !== 4'b0000 || ia.gnt !== 4'b0000 || ia.rdata !== 8'h00) begin bad++; $display("FAIL stray_done: done=%b gnt=%b rdata=%h want 0000/0000/00", ia.done, ia.gnt, ia.rdata); end
  endtask

  task automatic test_round_robin();
    bit seen;
    logic [NR-1:0] exp;
    rst = 1'b0;
    step();
    rst = 1'b1;
    ia.req_rw = 4'b0000; ia.m_rdata = 8'h3C; ia.req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      exp = 4'b0001 << (t % NR);
      for (int i = 0; i < 8; i++) begin
        if (ia.gnt != 4'b0000) break;
        step();
      end
      total++; if (ia.gnt !== exp) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", t, ia.gnt, exp); end
      wait_start_a(4, seen);
      total++; if (!seen) begin bad++; $display("FAIL rr_start[%0d]: got no m_start want one", t); end
      repeat (9) step();
      ia.m_done = 1'b1;
      step();
      ia.m_done = 1'b0;
      total++; if (ia.done !== exp || ia.rdata !== 8'h00) begin bad++; $display("FAIL rr_done[%0d]: done=%b rdata=%h want %b/00", t, ia.done, ia.rdata, exp); end
      step();
    end
    ia.req = '0; ia.m_rdata = 8'h00;
    repeat (3) step();
  endtask

  task automatic test_nack_write();
    bit seen;
    int wbad;
    ia.req_rw = 4'b0000;
    ia.req_addr = '0;  ia.req_addr[1*AW +: AW] = 7'h50;
    ia.req_wdata = '0; ia.req_wdata[1*DW +: DW] = 8'hA5;
    ia.m_rdata = 8'h77;
    ia.req = 4'b0010;
    step();
    total++; if (ia.gnt !== 4'b0010 || ia.m_addr !== 7'h50 || ia.m_rw !== 1'b0) begin bad++; $display("FAIL nack_latch: gnt=%b addr=%h rw=%b want 0010/50/0", ia.gnt, ia.m_addr, ia.m_rw); end
    ia.req_wdata = '0;
    ia.req_addr  = '0;
    wbad = 0;
    wait_start_a(4, seen);
    for (int i = 0; i < 5; i++) begin
      if (ia.m_wdata !== 8'hA5) wbad++;
      step();
    end
    ia.m_done = 1'b1; ia.m_nack = 1'b1;
    step();
    ia.m_done = 1'b0; ia.m_nack = 1'b0;
    if (ia.m_wdata !== 8'hA5) wbad++;
    total++; if (!seen || wbad != 0) begin bad++; $display("FAIL nack_wdata: start_seen=%b wdata=%h bad_cycles=%0d want 1/a5/0", seen, ia.m_wdata, wbad); end
    total++; if (ia.done !== 4'b0010 || ia.err !== 1'b1 || ia.rdata !== 8'h00) begin bad++; $display("FAIL nack_done: done=%b err=%b rdata=%h want 0010/1/00", ia.done, ia.err, ia.rdata); end
    ia.req = '0; ia.m_rdata = 8'h00;
    repeat (2) step();
  endtask

  task automatic test_busy_hold();
    bit seen;
    int hbad;
    ia.m_busy = 1'b1;
    ia.req = 4'b0001;
    step();
    total++; if (ia.gnt !== 4'b0001) begin bad++; $display("FAIL busy_gnt: got %b want 0001", ia.gnt); end
    hbad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ia.gnt !== 4'b0001 || ia.m_start !== 1'b0) hbad++;
    end
    total++; if (hbad != 0) begin bad++; $display("FAIL busy_hold: bad_cycles=%0d want 0 (gnt=%b start=%b)", hbad, ia.gnt, ia.m_start); end
    ia.m_busy = 1'b0;
    step();
    total++; if (ia.m_start !== 1'b1) begin bad++; $display("FAIL busy_release_start: got %b want 1", ia.m_start); end
    repeat (3) step();
    ia.m_done = 1'b1;
    step();
    ia.m_done = 1'b0;
    total++; if (ia.done !== 4'b0001) begin bad++; $display("FAIL busy_done: got %b want 0001", ia.done); end
    ia.req = '0;
    repeat (2) step();
  endtask

  task automatic test_timeout();
    bit seen;
    int n;
    ib.req_rw = 4'b0001; ib.m_rdata = 8'hC3; ib.req = 4'b0001;
    step();
    wait_start_b(4, seen);
    total++; if (!seen) begin bad++; $display("FAIL to_start: got no m_start want one"); end
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ib.m_abort) begin
        n = i;
        break;
      end
    end
    total++; if (n != 15) begin bad++; $display("FAIL to_abort_delay: got %0d cycles want 15", n); end
    total++; if (ib.done !== 4'b0001 || ib.err !== 1'b1 || ib.rdata !== 8'h00) begin bad++; $display("FAIL to_done: done=%b err=%b rdata=%h want 0001/1/00", ib.done, ib.err, ib.rdata); end
    ib.req = '0;
    step();
    total++; if (ib.m_abort !== 1'b0 || ib.done !== 4'b0000) begin bad++; $display("FAIL to_pulse_width: abort=%b done=%b want 0/0000", ib.m_abort, ib.done); end
    step();
  endtask

  task automatic test_timeout_tie();
    bit seen;
    int aborts;
    ib.req_rw = 4'b0001; ib.m_rdata = 8'h5A; ib.req = 4'b0001;
    step();
    wait_start_b(4, seen);
    aborts = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (ib.m_abort) aborts++;
    end
    ib.m_done = 1'b1; ib.m_nack = 1'b0;
    step();
    ib.m_done = 1'b0;
    if (ib.m_abort) aborts++;
    total++; if (!seen || aborts != 0) begin bad++; $display("FAIL tie_no_abort: start_seen=%b aborts=%0d want 1/0", seen, aborts); end
    total++; if (ib.done !== 4'b0001 || ib.err !== 1'b0 || ib.rdata !== 8'h5A) begin bad++; $display("FAIL tie_done: done=%b err=%b rdata=%h want 0001/0/5a", ib.done, ib.err, ib.rdata); end
    ib.req = '0;
    step();
    total++; if (ib.m_abort !== 1'b0) begin bad++; $display("FAIL tie_late_abort: got %b want 0", ib.m_abort); end
    ib.m_rdata = 8'h00;
    step();
  endtask

  task automatic test_reset_in_wait();
    bit seen;
    int dbad;
    ia.req_rw = 4'b0100; ia.req_addr = '0; ia.req_addr[2*AW +: AW] = 7'h33;
    ia.req = 4'b0100;
    step();
    wait_start_a(4, seen);
    repeat (3) step();
    rst = 1'b0;
    #1;
    total++; if (ia.gnt !== 4'b0000 || ia.m_rw !== 1'b0 || ia.m_addr !== 7'h00 || ia.done !== 4'b0000 || ia.m_abort !== 1'b0) begin bad++; $display("FAIL rstwait_async: gnt=%b rw=%b addr=%h done=%b abort=%b want all 0", ia.gnt, ia.m_rw, ia.m_addr, ia.done, ia.m_abort); end
    ia.req = 4'b1010; ia.req_rw = 4'b0000;
    dbad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (ia.done !== 4'b0000 || ia.m_abort !== 1'b0) dbad++;
    end
    total++; if (!seen || dbad != 0) begin bad++; $display("FAIL rstwait_silent: start_seen=%b bad_cycles=%0d want 1/0", seen, dbad); end
    rst = 1'b1;
    step();
    total++; if (ia.gnt !== 4'b0010) begin bad++; $display("FAIL rstwait_first_gnt: got %b want 0010", ia.gnt); end
    wait_start_a(4, seen);
    step();
    ia.m_done = 1'b1;
    step();
    ia.m_done = 1'b0;
    total++; if (ia.done !== 4'b0010) begin bad++; $display("FAIL rstwait_done: got %b want 0010", ia.done); end
    ia.req = '0;
    repeat (2) step();
  endtask

  initial begin
    init_inputs();
    test_reset();
    test_single_read();
    test_stray_done();
    test_round_robin();
    test_nack_write();
    test_busy_hold();
    test_timeout();
    test_timeout_tie();
    test_reset_in_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
